// File: rtl/spi_master_mmio.sv
// rtl/spi_master_mmio.sv - MMIO SPI master (mode 0, MSB first) with TX/RX FIFOs; optional SPI_LOOPBACK_EN

// Synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module spi_master_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

module spi_master_mmio #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_wr,
    input  logic       spi_rd,
    input  logic       spi_addr,
    input  logic [7:0] spi_din,
    input  logic       spi_ignore_response,
    output logic [7:0] spi_dout,
    output logic       spi_buffer_full,
    output logic       spi_buffer_empty,
    output logic       spi_data_avail,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = 1;
    localparam logic [3:0]    HALF_LAST = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [3:0]    r_half;
    logic [3:0]    w_half_nxt;
    logic          r_sclk;
    logic          w_sclk_nxt;
    logic          r_mosi;
    logic          w_mosi_nxt;
    logic          r_cs_n;
    logic          w_cs_n_nxt;
    logic [7:0]    r_tx_sh;
    logic [7:0]    w_tx_sh_nxt;
    logic [7:0]    r_rx_sh;
    logic [7:0]    w_rx_sh_nxt;
    logic          r_ignore;
    logic          w_ignore_nxt;

    logic          w_tx_pop;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic [8:0]    w_tx_data;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [7:0]    w_rx_data;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_div_end;
    logic          w_rx_in;

    spi_master_mmio_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (spi_wr),
        .i_data  ({spi_ignore_response, spi_din}),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    spi_master_mmio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_data  (r_rx_sh),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Status reads (addr 1) never consume RX data.
    assign w_rx_pop  = spi_rd && !spi_addr;
    assign w_div_end = (r_div == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
    // Sample the bit being driven this edge; on a back-to-back frame start that is the new MSB.
    assign w_rx_in = (r_state == S_TRAIL) ? w_tx_data[7] : r_mosi;
`else
    assign w_rx_in = miso;
`endif

    assign spi_dout         = w_rx_empty ? 8'h00 : w_rx_data;
    assign spi_buffer_full  = w_tx_full;
    assign spi_buffer_empty = w_tx_empty && (r_state == S_IDLE);
    assign spi_data_avail   = !w_rx_empty;
    assign sclk             = r_sclk;
    assign mosi             = r_mosi;
    assign cs_n             = r_cs_n;

    // Engine state and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_half   <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_tx_sh  <= '0;
            r_rx_sh  <= '0;
            r_ignore <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_half   <= w_half_nxt;
            r_sclk   <= w_sclk_nxt;
            r_mosi   <= w_mosi_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_tx_sh  <= w_tx_sh_nxt;
            r_rx_sh  <= w_rx_sh_nxt;
            r_ignore <= w_ignore_nxt;
        end
    end

    // Next-state logic: each divider wrap ends a lead, half-period or trail phase.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = (r_state == S_IDLE || w_div_end) ? '0 : r_div + DIV_ONE;
        w_half_nxt   = r_half;
        w_sclk_nxt   = r_sclk;
        w_mosi_nxt   = r_mosi;
        w_cs_n_nxt   = r_cs_n;
        w_tx_sh_nxt  = r_tx_sh;
        w_rx_sh_nxt  = r_rx_sh;
        w_ignore_nxt = r_ignore;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_sh_nxt  = w_tx_data[7:0];
                    w_ignore_nxt = w_tx_data[8];
                    w_mosi_nxt   = w_tx_data[7];
                    w_cs_n_nxt   = 1'b0;
                    w_div_nxt    = '0;
                    w_state_nxt  = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_div_end) begin
                    w_sclk_nxt  = 1'b1;
                    w_half_nxt  = '0;
                    w_rx_sh_nxt = {r_rx_sh[6:0], w_rx_in};
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    if (r_half == HALF_LAST) begin
                        w_sclk_nxt  = 1'b0;
                        w_rx_push   = !r_ignore;
                        w_state_nxt = S_TRAIL;
                    end else begin
                        w_half_nxt = r_half + 4'd1;
                        w_sclk_nxt = !r_sclk;
                        if (r_sclk) begin
                            w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                            w_mosi_nxt  = r_tx_sh[6];
                        end else begin
                            w_rx_sh_nxt = {r_rx_sh[6:0], w_rx_in};
                        end
                    end
                end
            end
            S_TRAIL: begin
                if (w_div_end) begin
                    if (!w_tx_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_sh_nxt  = w_tx_data[7:0];
                        w_ignore_nxt = w_tx_data[8];
                        w_mosi_nxt   = w_tx_data[7];
                        w_sclk_nxt   = 1'b1;
                        w_half_nxt   = '0;
                        w_rx_sh_nxt  = {r_rx_sh[6:0], w_rx_in};
                        w_state_nxt  = S_SHIFT;
                    end else begin
                        w_cs_n_nxt  = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule
